id_ex_pipe_u: RTL and testbench

- ID/EX pipeline register of the 5-stage RV32I core. It sits directly downstream of data_forward_u and consumes its forward_a/forward_b codes.
- Selects each source operand from three places: register-file read data, the EX-stage result, or the MEM-stage result. The chosen operands are registered into EX.
- Detects load-use hazards from its own registered EX-slot state. On a hazard it raises stall to IF/ID and inserts a one-cycle bubble.
- Supports flush (taken branch/jump) and hold (downstream freeze).

---
 rtl/rv32i_pkg.sv | 21 ++
 rtl/operand_mux_u.sv | 30 +++
 rtl/id_ex_pipe_u.sv | 122 ++++++++++++
 tb/tb_id_ex_pipe_u.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: forwarding select codes, control
// bundle width, and the field values that make up an EX-slot bubble.
package rv32i_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_EX   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_e;

    localparam int unsigned   CTRL_W   = 16;
    localparam logic [15:0]   CTRL_NOP = 16'h0000;

    // A bubble is an invalid slot that neither writes the register file
    // nor looks like a load to the hazard check.
    localparam logic          BUBBLE_VALID    = 1'b0;
    localparam logic          BUBBLE_WR_REG_N = 1'b1;
    localparam logic          BUBBLE_IS_LOAD  = 1'b0;
    localparam logic [4:0]    BUBBLE_RD       = 5'd0;

endpackage

// File: rtl/operand_mux_u.sv
// Source-operand select: register file, EX-stage result or MEM-stage
// result, chosen by the data_forward_u code. Register x0 always reads 0.
module operand_mux_u
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [4:0]      rs,
    input  logic [1:0]      fwd,
    input  logic [XLEN-1:0] rf_data,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] mem_result,
    output logic [XLEN-1:0] operand
);

    // x0 gating wins over any forward code; 00 and 11 fall back to the rf
    always_comb begin
        operand = rf_data;
        if (rs == 5'd0) begin
            operand = '0;
        end else begin
            case (fwd)
                FWD_EX:  operand = ex_result;
                FWD_MEM: operand = mem_result;
                default: operand = rf_data;
            endcase
        end
    end

endmodule

// File: rtl/id_ex_pipe_u.sv
// ID/EX pipeline register for the 5-stage RV32I core. Resolves both
// source operands through forwarding, detects load-use hazards against
// the registered EX slot, and handles flush/hold.
// Optional: define ID_EX_STALL_CNT_EN to build a saturating load-use
// stall counter on stall_cnt; otherwise stall_cnt is tied to 0.
module id_ex_pipe_u
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = rv32i_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_wr_reg_n,
    input  logic              id_is_load,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]   rf_rs1_data,
    input  logic [XLEN-1:0]   rf_rs2_data,
    input  logic [1:0]        forward_a,
    input  logic [1:0]        forward_b,
    input  logic [XLEN-1:0]   ex_result,
    input  logic [XLEN-1:0]   mem_result,
    input  logic              flush,
    input  logic              hold,
    output logic              stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_val,
    output logic [XLEN-1:0]   ex_rs2_val,
    output logic [4:0]        ex_rd,
    output logic              ex_wr_reg_n,
    output logic              ex_is_load,
    output logic [XLEN-1:0]   ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [31:0]       stall_cnt
);

    import rv32i_pkg::*;

    logic [XLEN-1:0] rs1_sel;
    logic [XLEN-1:0] rs2_sel;
    logic            haz;

    operand_mux_u #(.XLEN(XLEN)) u_mux_rs1 (
        .rs         (id_rs1),
        .fwd        (forward_a),
        .rf_data    (rf_rs1_data),
        .ex_result  (ex_result),
        .mem_result (mem_result),
        .operand    (rs1_sel)
    );

    operand_mux_u #(.XLEN(XLEN)) u_mux_rs2 (
        .rs         (id_rs2),
        .fwd        (forward_b),
        .rf_data    (rf_rs2_data),
        .ex_result  (ex_result),
        .mem_result (mem_result),
        .operand    (rs2_sel)
    );

    // Load-use hazard: EX holds a real, register-writing load whose rd feeds ID
    assign haz = id_valid & ex_valid & ex_is_load & ~ex_wr_reg_n &
                 (ex_rd != 5'd0) & ((id_rs1 == ex_rd) | (id_rs2 == ex_rd));

    // A flush discards the dependent instruction, so no stall is needed
    assign stall = haz & ~flush;

    // EX slot register: flush > hold > hazard bubble > normal capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= BUBBLE_VALID;
            ex_pc       <= '0;
            ex_rs1_val  <= '0;
            ex_rs2_val  <= '0;
            ex_rd       <= BUBBLE_RD;
            ex_wr_reg_n <= BUBBLE_WR_REG_N;
            ex_is_load  <= BUBBLE_IS_LOAD;
            ex_imm      <= '0;
            ex_ctrl     <= CTRL_W'(CTRL_NOP);
        end else if (flush || (!hold && haz)) begin
            ex_valid    <= BUBBLE_VALID;
            ex_pc       <= '0;
            ex_rs1_val  <= '0;
            ex_rs2_val  <= '0;
            ex_rd       <= BUBBLE_RD;
            ex_wr_reg_n <= BUBBLE_WR_REG_N;
            ex_is_load  <= BUBBLE_IS_LOAD;
            ex_imm      <= '0;
            ex_ctrl     <= CTRL_W'(CTRL_NOP);
        end else if (!hold) begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rs1_val  <= rs1_sel;
            ex_rs2_val  <= rs2_sel;
            ex_rd       <= id_rd;
            ex_wr_reg_n <= id_wr_reg_n | ~id_valid;
            ex_is_load  <= id_is_load & id_valid;
            ex_imm      <= id_imm;
            ex_ctrl     <= id_ctrl;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    // Count un-held stall cycles, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && !hold && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_u.sv
// Self-checking bench for id_ex_pipe_u: directed scenarios followed by
// randomized traffic, all compared against a behavioural EX-slot model.
module tb_id_ex_pipe_u;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_wr_reg_n, id_is_load;
    logic [31:0] id_imm;
    logic [15:0] id_ctrl;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic [1:0]  forward_a, forward_b;
    logic [31:0] ex_result, mem_result;
    logic        flush, hold;
    logic        stall, ex_valid, ex_wr_reg_n, ex_is_load;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, stall_cnt;
    logic [4:0]  ex_rd;
    logic [15:0] ex_ctrl;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    id_ex_pipe_u #(.XLEN(32), .CTRL_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_wr_reg_n(id_wr_reg_n), .id_is_load(id_is_load), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .forward_a(forward_a), .forward_b(forward_b), .ex_result(ex_result),
        .mem_result(mem_result), .flush(flush), .hold(hold), .stall(stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
        .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd), .ex_wr_reg_n(ex_wr_reg_n),
        .ex_is_load(ex_is_load), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .stall_cnt(stall_cnt)
    );

    // Reference view of the EX slot
    typedef struct {
        bit        valid;
        bit [31:0] pc, rs1v, rs2v, imm;
        bit [4:0]  rd;
        bit        wr_n, is_load;
        bit [15:0] ctrl;
    } slot_t;

    slot_t     m;
    bit [31:0] m_cnt;

    function automatic slot_t bubble();
        slot_t b;
        b = '{valid: 1'b0, pc: 32'd0, rs1v: 32'd0, rs2v: 32'd0, imm: 32'd0,
              rd: 5'd0, wr_n: 1'b1, is_load: 1'b0, ctrl: 16'd0};
        return b;
    endfunction

    function automatic bit [31:0] pick(bit [4:0] rs, bit [1:0] code, bit [31:0] rf,
                                       bit [31:0] exr, bit [31:0] memr);
        if (rs == 0)     return 32'd0;
        if (code == 2'd1) return exr;
        if (code == 2'd2) return memr;
        return rf;
    endfunction

    function automatic bit model_haz();
        bit uses;
        uses = (id_rs1 == m.rd) || (id_rs2 == m.rd);
        return id_valid && m.valid && m.is_load && !m.wr_n && (m.rd != 0) && uses;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_slot();
        check("ex_valid",    ex_valid,    m.valid);
        check("ex_pc",       ex_pc,       m.pc);
        check("ex_rs1_val",  ex_rs1_val,  m.rs1v);
        check("ex_rs2_val",  ex_rs2_val,  m.rs2v);
        check("ex_rd",       ex_rd,       m.rd);
        check("ex_wr_reg_n", ex_wr_reg_n, m.wr_n);
        check("ex_is_load",  ex_is_load,  m.is_load);
        check("ex_imm",      ex_imm,      m.imm);
        check("ex_ctrl",     ex_ctrl,     m.ctrl);
        check("stall_cnt",   stall_cnt,   m_cnt);
    endtask

    // One clock: check stall before the edge, advance the model, check slot after
    task automatic step();
        bit    h;
        slot_t n;
        #1;
        h = model_haz();
        check("stall", stall, h && !flush);
        @(posedge clk);
`ifdef ID_EX_STALL_CNT_EN
        if (h && !flush && !hold && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
        if (flush || (!hold && h)) begin
            m = bubble();
        end else if (!hold) begin
            n.valid   = id_valid;
            n.pc      = id_pc;
            n.rs1v    = pick(id_rs1, forward_a, rf_rs1_data, ex_result, mem_result);
            n.rs2v    = pick(id_rs2, forward_b, rf_rs2_data, ex_result, mem_result);
            n.rd      = id_rd;
            n.imm     = id_imm;
            n.ctrl    = id_ctrl;
            n.wr_n    = id_valid ? id_wr_reg_n : 1'b1;
            n.is_load = id_valid ? id_is_load : 1'b0;
            m = n;
        end
        #1;
        check_slot();
    endtask

    task automatic set_idle();
        id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_wr_reg_n = 1; id_is_load = 0; id_imm = 0; id_ctrl = 0;
        rf_rs1_data = 0; rf_rs2_data = 0; forward_a = 0; forward_b = 0;
        ex_result = 0; mem_result = 0; flush = 0; hold = 0;
    endtask

    task automatic rand_id();
        id_valid    = ($urandom_range(0, 9) < 8);
        id_pc       = $urandom;
        id_rs1      = 5'($urandom_range(0, 7));
        id_rs2      = 5'($urandom_range(0, 7));
        id_rd       = 5'($urandom_range(0, 7));
        id_wr_reg_n = ($urandom_range(0, 3) == 0);
        id_is_load  = ($urandom_range(0, 9) < 4);
        id_imm      = $urandom;
        id_ctrl     = 16'($urandom);
        rf_rs1_data = $urandom;
        rf_rs2_data = $urandom;
        forward_a   = 2'($urandom_range(0, 3));
        forward_b   = 2'($urandom_range(0, 3));
        ex_result   = $urandom;
        mem_result  = $urandom;
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        m = bubble();
        m_cnt = 0;
        #12;
        check_slot();
        check("rst_stall", stall, 1'b0);
        rst = 1'b0;

        // EX forward
        id_valid = 1; id_pc = 32'h100; id_rs1 = 5; id_rd = 1; id_wr_reg_n = 0;
        forward_a = 2'b01; ex_result = 32'hDEADBEEF; rf_rs1_data = 32'h11111111;
        step();
        check("ex_fwd", ex_rs1_val, 32'hDEADBEEF);

        // MEM forward on rs2, x0 gating on rs1
        id_rs1 = 0; forward_a = 2'b01; ex_result = 32'hFFFFFFFF;
        id_rs2 = 9; forward_b = 2'b10; mem_result = 32'h00001234;
        step();
        check("mem_fwd", ex_rs2_val, 32'h00001234);
        check("x0_gate", ex_rs1_val, 32'd0);

        // Load-use: load to x7, then a consumer of x7
        set_idle();
        id_valid = 1; id_is_load = 1; id_wr_reg_n = 0; id_rd = 7; id_rs1 = 1; id_rs2 = 2;
        step();
        id_is_load = 0; id_rd = 2; id_rs1 = 1; id_rs2 = 7;
        #1 check("lu_stall", stall, 1'b1);
        step();
        check("lu_bubble", ex_valid, 1'b0);
        forward_b = 2'b10; mem_result = 32'hCAFE0000;
        #1 check("lu_released", stall, 1'b0);
        step();
        check("lu_mem_fwd", ex_rs2_val, 32'hCAFE0000);

        // Loads to x0 or to an unrelated register never stall
        set_idle();
        id_valid = 1; id_is_load = 1; id_wr_reg_n = 0; id_rd = 0;
        step();
        id_is_load = 0; id_rs1 = 0; id_rd = 1;
        #1 check("x0_load_nostall", stall, 1'b0);
        step();
        id_is_load = 1; id_rd = 3;
        step();
        id_is_load = 0; id_rs1 = 4; id_rs2 = 5; id_rd = 1;
        #1 check("unrel_nostall", stall, 1'b0);
        step();

        // Hold for three cycles while ID changes, then flush with hold
        id_pc = 32'h4000; id_rd = 6;
        step();
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            step();
            check("hold_pc", ex_pc, 32'h4000);
        end
        flush = 1;
        step();
        check("flush_hold", ex_valid, 1'b0);
        flush = 0; hold = 0;

        // Held load-use stall: stall asserted, slot and counter frozen
        set_idle();
        id_valid = 1; id_is_load = 1; id_wr_reg_n = 0; id_rd = 4;
        step();
        id_is_load = 0; id_rs1 = 4; hold = 1;
        step();
        step();
        hold = 0;
        step();

        // Asynchronous reset between edges with a live slot
        set_idle();
        id_valid = 1; id_rd = 5; id_wr_reg_n = 0; id_pc = 32'h80;
        step();
        #2 rst = 1'b1;
        m = bubble();
        m_cnt = 0;
        #1;
        check_slot();
        check("async_rst_wr_n", ex_wr_reg_n, 1'b1);
        #1 rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_id();
            flush = ($urandom_range(0, 9) == 0);
            hold  = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
